// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: register map, CTRL bit layout
// and the CTRL readback packing.
package timer_pkg;

    localparam logic [1:0] TMR_CTRL     = 2'd0;
    localparam logic [1:0] TMR_PRESCALE = 2'd1;
    localparam logic [1:0] TMR_RELOAD   = 2'd2;
    localparam logic [1:0] TMR_COUNT    = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_EXPIRED  = 15;

    localparam logic [9:0] TMR_BASE_ADDR = 10'h108;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ctrl_t;

    // Unused CTRL bits always read back as zero.
    function automatic logic [15:0] ctrl_word(input ctrl_t c, input logic expired);
        logic [15:0] w;
        w                = 16'h0000;
        w[CTRL_EN]       = c.en;
        w[CTRL_PERIODIC] = c.periodic;
        w[CTRL_IRQ_EN]   = c.irq_en;
        w[CTRL_EXPIRED]  = expired;
        return w;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler for the interval timer: emits a one-cycle tick every div+1
// enabled clocks; restart reloads the count and suppresses that cycle's tick.
module tick_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] pcnt;

    assign tick = en && !restart && (pcnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= 16'd0;
        end else if (restart) begin
            pcnt <= div;
        end else if (en) begin
            if (pcnt == 16'd0)
                pcnt <= div;
            else
                pcnt <= pcnt - 16'd1;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Memory-mapped programmable interval timer: register file, down-counter,
// expiry/interrupt logic and combinational read mux.
module interval_timer
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        irq
);

    ctrl_t       ctrl;
    logic        expired;
    logic [15:0] prescale;
    logic [15:0] reload;
    logic [15:0] count;

    logic wr_ctrl, wr_prescale, wr_reload;
    logic restart, tick, tick_ok;

    assign wr_ctrl     = wr && (addr == TMR_CTRL);
    assign wr_prescale = wr && (addr == TMR_PRESCALE);
    assign wr_reload   = wr && (addr == TMR_RELOAD);

    // Prescaler restarts on a RELOAD write or when EN goes 0->1.
    assign restart = wr_reload || (wr_ctrl && din[CTRL_EN] && !ctrl.en);
    // A CTRL write that disables the timer swallows a coincident tick.
    assign tick_ok = tick && !(wr_ctrl && !din[CTRL_EN]);

    tick_divider u_div (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl.en),
        .restart (restart),
        .div     (prescale),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            expired  <= 1'b0;
            prescale <= 16'd0;
            reload   <= 16'd0;
            count    <= 16'd0;
        end else begin
            if (wr_ctrl && din[CTRL_EXPIRED])
                expired <= 1'b0;
            if (wr_reload) begin
                count <= din;
            end else if (tick_ok) begin
                if (count != 16'd0) begin
                    count <= count - 16'd1;
                end else begin
                    // Expiry is ordered after the clear so it wins a tie.
                    expired <= 1'b1;
                    if (ctrl.periodic)
                        count <= reload;
                    else
                        ctrl.en <= 1'b0;
                end
            end
            // Software CTRL writes override the one-shot auto-disable.
            if (wr_ctrl) begin
                ctrl.en       <= din[CTRL_EN];
                ctrl.periodic <= din[CTRL_PERIODIC];
                ctrl.irq_en   <= din[CTRL_IRQ_EN];
            end
            if (wr_prescale)
                prescale <= din;
            if (wr_reload)
                reload <= din;
        end
    end

    always_comb begin
        dout = 16'h0000;
        case (addr)
            TMR_CTRL:     dout = ctrl_word(ctrl, expired);
            TMR_PRESCALE: dout = prescale;
            TMR_RELOAD:   dout = reload;
            TMR_COUNT:    dout = count;
            default:      dout = 16'h0000;
        endcase
    end

    assign irq = expired && ctrl.irq_en;

endmodule

// File: tb/tb_interval_timer.sv
// Testbench for interval_timer: register table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_interval_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    interval_timer dut (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_en, m_per, m_ie, m_exp;
    logic [15:0] m_pre, m_rel, m_cnt, m_pcnt;

    function automatic void model_step(bit r, bit w, logic [1:0] a, logic [15:0] d);
        bit do_ctrl, do_reload, restart, tick, stop, expire;
        if (r) begin
            m_en = 0; m_per = 0; m_ie = 0; m_exp = 0;
            m_pre = 0; m_rel = 0; m_cnt = 0; m_pcnt = 0;
            return;
        end
        do_ctrl   = w && a == 2'd0;
        do_reload = w && a == 2'd2;
        restart   = do_reload || (do_ctrl && d[0] && !m_en);
        tick = 0; stop = 0; expire = 0;
        if (restart) m_pcnt = m_pre;
        else if (m_en) begin
            if (m_pcnt == 0) begin tick = 1; m_pcnt = m_pre; end
            else m_pcnt = m_pcnt - 16'd1;
        end
        if (do_ctrl && !d[0]) tick = 0;
        if (do_reload) m_cnt = d;
        else if (tick) begin
            if (m_cnt != 0) m_cnt = m_cnt - 16'd1;
            else begin
                expire = 1;
                if (m_per) m_cnt = m_rel;
                else stop = 1;
            end
        end
        m_exp = expire || (m_exp && !(do_ctrl && d[15]));
        if (do_ctrl) begin m_en = d[0]; m_per = d[1]; m_ie = d[2]; end
        else if (stop) m_en = 0;
        if (w && a == 2'd1) m_pre = d;
        if (do_reload) m_rel = d;
    endfunction

    function automatic logic [15:0] model_read(logic [1:0] a);
        case (a)
            2'd0: return {m_exp, 12'h000, m_ie, m_per, m_en};
            2'd1: return m_pre;
            2'd2: return m_rel;
            default: return m_cnt;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: model follows the inputs present at the edge; outputs sampled #1 later.
    task automatic step();
        @(posedge clk);
        model_step(reset, wr, addr, din);
        #1;
    endtask

    task automatic drive(input bit w, input logic [1:0] a, input logic [15:0] d);
        wr = w; addr = a; din = d;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
        drive(1, a, d);
        step();
        wr = 0;
    endtask

    task automatic do_reset();
        reset = 1; drive(0, 0, 0);
        step();
        reset = 0;
    endtask

    typedef struct {
        bit          w;
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[11];

    initial begin
        reset = 1; wr = 0; addr = 0; din = 0;

        tbl[0]  = '{0, 2'd0, 16'h0000, 16'h0000, 0};
        tbl[1]  = '{0, 2'd1, 16'h0000, 16'h0000, 0};
        tbl[2]  = '{0, 2'd2, 16'h0000, 16'h0000, 0};
        tbl[3]  = '{0, 2'd3, 16'h0000, 16'h0000, 0};
        tbl[4]  = '{1, 2'd1, 16'h1234, 16'h1234, 0};
        tbl[5]  = '{1, 2'd2, 16'h0003, 16'h0003, 0};
        tbl[6]  = '{0, 2'd3, 16'h0000, 16'h0003, 0};
        tbl[7]  = '{1, 2'd3, 16'hFFFF, 16'h0003, 0};
        tbl[8]  = '{1, 2'd0, 16'hFFF8, 16'h0000, 0};
        tbl[9]  = '{1, 2'd0, 16'h0006, 16'h0006, 0};
        tbl[10] = '{1, 2'd0, 16'h0000, 16'h0000, 0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].w, tbl[i].a, tbl[i].d);
            step();
            check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
            check($sformatf("tbl%0d_irq", i), 16'(irq), 16'(tbl[i].exp_irq));
        end

        // Periodic, 20-clock period, clear in between
        do_reset();
        write_reg(2'd1, 16'd3);
        write_reg(2'd2, 16'd4);
        write_reg(2'd0, 16'h0007);
        for (int n = 1; n <= 40; n++) begin
            if (n == 21) drive(1, 2'd0, 16'h8007);
            else drive(0, 2'd3, 16'h0000);
            step();
            check($sformatf("per_irq_n%0d", n), 16'(irq), 16'(n == 20 || n == 40));
            if (n <= 20 && n % 4 == 0)
                check($sformatf("per_count_n%0d", n), dout, (n == 20) ? 16'd4 : 16'(4 - n / 4));
            if (n == 21) check("per_clear_ctrl", dout, 16'h0007);
        end

        // One-shot, PRESCALE=0
        do_reset();
        write_reg(2'd2, 16'd2);
        write_reg(2'd0, 16'h0005);
        for (int n = 1; n <= 3; n++) begin
            drive(0, 2'd3, 0);
            step();
            check($sformatf("os_irq_n%0d", n), 16'(irq), 16'(n == 3));
        end
        drive(0, 2'd0, 0); step();
        check("os_ctrl", dout, 16'h8004);
        drive(0, 2'd3, 0); step(); step(); step();
        check("os_count_hold", dout, 16'h0000);
        write_reg(2'd0, 16'h8004);
        check("os_clear_ctrl", dout, 16'h0004);
        check("os_clear_irq", 16'(irq), 16'd0);

        // Clear on the exact expiry edge, then reset mid-count
        do_reset();
        write_reg(2'd2, 16'd5);
        write_reg(2'd0, 16'h0007);
        for (int n = 1; n <= 5; n++) begin drive(0, 2'd3, 0); step(); end
        check("tie_count0", dout, 16'h0000);
        write_reg(2'd0, 16'h8007);
        check("tie_ctrl", dout, 16'h8007);
        check("tie_irq", 16'(irq), 16'd1);
        drive(0, 2'd0, 0); step();
        check("tie_irq_hold", 16'(irq), 16'd1);
        do_reset();
        check("rst_irq", 16'(irq), 16'd0);
        check("rst_ctrl", dout, 16'h0000);
        drive(0, 2'd3, 0); step();
        check("rst_count", dout, 16'h0000);

        // RELOAD write on a tick edge
        do_reset();
        write_reg(2'd1, 16'd2);
        write_reg(2'd2, 16'd5);
        write_reg(2'd0, 16'h0003);
        for (int n = 1; n <= 8; n++) begin
            drive(0, 2'd3, 0); step();
            if (n == 6) check("rl_count_pre", dout, 16'd3);
        end
        write_reg(2'd2, 16'h0010);
        check("rl_reload_rb", dout, 16'h0010);
        for (int n = 10; n <= 12; n++) begin
            drive(0, 2'd3, 0); step();
            check($sformatf("rl_count_n%0d", n), dout, (n == 12) ? 16'h000F : 16'h0010);
        end

        // IRQ_EN=0: EXPIRED sets silently, enabling IRQ_EN raises irq
        do_reset();
        write_reg(2'd2, 16'd1);
        write_reg(2'd0, 16'h0003);
        drive(0, 2'd0, 0); step(); step();
        check("ie_ctrl", dout, 16'h8003);
        check("ie_irq_off", 16'(irq), 16'd0);
        write_reg(2'd0, 16'h0007);
        check("ie_irq_on", 16'(irq), 16'd1);

        // CTRL write with EN=0 on a tick edge discards that tick
        do_reset();
        write_reg(2'd2, 16'd3);
        write_reg(2'd0, 16'h0001);
        drive(0, 2'd3, 0); step();
        check("dis_count_a", dout, 16'd2);
        write_reg(2'd0, 16'h0000);
        drive(0, 2'd3, 0); step(); step();
        check("dis_count_b", dout, 16'd2);

        // One-shot expiry coinciding with a CTRL EN=1 write
        do_reset();
        write_reg(2'd2, 16'd1);
        write_reg(2'd0, 16'h0001);
        drive(0, 2'd3, 0); step();
        write_reg(2'd0, 16'h0001);
        check("osw_ctrl", dout, 16'h8001);
        drive(0, 2'd0, 0); step();
        check("osw_ctrl_next", dout, 16'h8000);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [1:0]  a;
            logic [15:0] d;
            bit          w;
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0);
            case (a)
                2'd0: begin
                    d = 16'($urandom);
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                end
                2'd1: d = 16'($urandom_range(0, 3));
                2'd2: d = 16'($urandom_range(0, 9));
                default: d = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 999) == 0);
            drive(w, a, d);
            step();
            check($sformatf("rnd%0d_dout_a%0d", c, a), dout, model_read(a));
            check($sformatf("rnd%0d_irq", c), 16'(irq), 16'(m_exp && m_ie));
        end
        reset = 0; wr = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
